tia_beam_scheduler: RTL and testbench
=====================================

Name: tia_beam_scheduler

Overview:
Beam-timing sequencer for the TIA datapath. It generates the colour-clock horizontal and vertical counters and the blanking windows. It stalls the CPU for WSYNC, applies the HMOVE blank extension, and issues visible-pixel requests with a valid/ready handshake to the LCD pixel pusher. It sits between the TIA Wishbone register file, which supplies the strobes and levels, and the pixel/LCD path.

Parameters:
H_TOTAL, 228, colour clocks per scanline
H_BLANK, 68, horizontal blank length in colour clocks
HMOVE_EXT, 8, extra blank clocks on a line with HMOVE
V_TOTAL, 262, maximum scanlines per frame before overrun
V_FIRST, 40, first scanline forwarded to the pixel path
V_LINES, 192, number of scanlines forwarded

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
cc_en_i  in  1  colour-clock enable, one-cycle strobe
wsync_i  in  1  WSYNC write strobe
rsync_i  in  1  RSYNC write strobe
hmove_i  in  1  HMOVE write strobe
vsync_i  in  1  VSYNC register bit (level)
vblank_i  in  1  VBLANK register bit (level)
clr_err_i  in  1  clears sticky error flags
pix_ready_i  in  1  pixel consumer ready
cpu_rdy_o  out  1  CPU may proceed; low during a WSYNC halt
hcount_o  out  8  colour clock within the line, 0..H_TOTAL-1
vcount_o  out  9  scanline within the frame
hblank_o  out  1  horizontal blank active
line_start_o  out  1  one-clk pulse at line wrap
frame_start_o  out  1  one-clk pulse at the first line of a frame
pix_valid_o  out  1  pixel request valid
pix_x_o  out  8  visible x, hcount - H_BLANK
pix_y_o  out  8  visible y, vcount - V_FIRST
pix_drop_o  out  1  sticky: pixel request lost
frame_ovr_o  out  1  sticky: vcount reached V_TOTAL without VSYNC

Behaviour:
- Reset (rst_ni low, asynchronous):
  - counters are 0 and the FSM is RUN;
  - cpu_rdy_o=1, hblank_o=1; all pulses, pix_valid_o and sticky flags are 0;
  - pix_x_o/pix_y_o are 0.
  - A reset mid-halt releases the CPU immediately.
- State updates only on clk_i edges. Counters advance only when cc_en_i=1.
- Wrap event = cc_en_i && hcount==H_TOTAL-1. On wrap:
  - hcount goes to 0 and line_start_o pulses in the following cycle;
  - vcount increments, saturating at V_TOTAL-1. Reaching V_TOTAL-1 sets frame_ovr_o.
- rsync_i loads hcount=H_TOTAL-3 regardless of cc_en_i. It has priority over wrap and increment in the same cycle.
- VSYNC:
  - A falling edge of vsync_i (registered compare) arms frame_pend.
  - At the next wrap with frame_pend set, vcount goes to 0 instead of incrementing, frame_pend clears, and frame_start_o pulses together with line_start_o.
- HMOVE:
  - hmove_i while hcount<H_BLANK sets hmove_ext for the current line. hmove_i at other times is ignored.
  - hmove_ext clears at wrap.
  - hblank_o = hcount<H_BLANK, or hcount<H_BLANK+HMOVE_EXT when hmove_ext=1. It is registered and aligned with hcount_o.
- WSYNC FSM, two states RUN/HALT:
  - RUN: wsync_i moves to HALT; cpu_rdy_o=0 from the next cycle.
  - HALT: wrap moves to RUN; cpu_rdy_o=1 the cycle after the wrap.
  - wsync_i while in HALT is ignored.
  - wsync_i in the same cycle as a wrap enters HALT and releases at the following wrap (full line).
  - rsync_i does not release HALT; only the wrap it produces does.
- Pixel request:
  - Generated on cc_en_i when !hblank (next-state), !vblank_i, and V_FIRST<=vcount<V_FIRST+V_LINES.
  - pix_valid_o, pix_x_o and pix_y_o are registered one cycle after that cc_en_i.
  - Handshake: the transfer occurs when pix_valid_o && pix_ready_i; pix_valid_o then drops unless a new request loads in the same cycle.
  - New request while pix_valid_o && !pix_ready_i: the held pixel is kept, the new one is discarded, and pix_drop_o is set.
- Sticky flags clear on clr_err_i. A set event in the same cycle as the clear wins.

Test Plan:
- Free-run, cc_en_i every cycle, vsync_i=0:
  - hcount_o counts 0..227 and wraps;
  - line_start_o pulses every 228 clocks;
  - vcount_o increments and saturates at 261;
  - frame_ovr_o sets at line 261.
- wsync_i at hcount=100: cpu_rdy_o=0 next cycle, returns to 1 the cycle after hcount 227->0 wrap. Repeat at hcount=227: CPU held a full extra line.
- hmove_i at hcount=10: hblank_o high for hcount 0..75 on that line, 0..67 on the next. hmove_i at hcount=120: no extension.
- vsync_i pulse 1->0 at vcount=5: next wrap gives vcount_o=0 with frame_start_o and line_start_o pulsing together.
- vcount=40, vblank_i=0, pix_ready_i=1: 160 requests with pix_x_o 0..159, pix_y_o=0. With pix_ready_i=0: first pixel held at x=0 and pix_drop_o set; clr_err_i clears it.
- rsync_i at hcount=50 coincident with wsync_i: hcount=225, wrap 3 cc later, cpu_rdy_o low until that wrap.

Source files
------------

// File: rtl/tia_beam_scheduler_if.sv
// Purpose: bundles the TIA beam-scheduler strobes, levels, beam status and pixel request bus.
// Latency: none, wiring only.
// Backpressure: pixel requests use pix_valid_o/pix_ready_i; the CPU stalls on cpu_rdy_o.
//
// Ports (seen from the scheduler, modport slave):
//   in : cc_en_i, wsync_i, rsync_i, hmove_i, vsync_i, vblank_i, clr_err_i, pix_ready_i
//   out: cpu_rdy_o, hcount_o, vcount_o, hblank_o, line_start_o, frame_start_o,
//        pix_valid_o, pix_x_o, pix_y_o, pix_drop_o, frame_ovr_o
// The master modport is the register-file / pixel-path side that drives the inputs.
interface tia_beam_scheduler_if;
    logic       cc_en_i;
    logic       wsync_i;
    logic       rsync_i;
    logic       hmove_i;
    logic       vsync_i;
    logic       vblank_i;
    logic       clr_err_i;
    logic       pix_ready_i;

    logic       cpu_rdy_o;
    logic [7:0] hcount_o;
    logic [8:0] vcount_o;
    logic       hblank_o;
    logic       line_start_o;
    logic       frame_start_o;
    logic       pix_valid_o;
    logic [7:0] pix_x_o;
    logic [7:0] pix_y_o;
    logic       pix_drop_o;
    logic       frame_ovr_o;

    modport master (
        output cc_en_i, wsync_i, rsync_i, hmove_i, vsync_i, vblank_i, clr_err_i, pix_ready_i,
        input  cpu_rdy_o, hcount_o, vcount_o, hblank_o, line_start_o, frame_start_o,
               pix_valid_o, pix_x_o, pix_y_o, pix_drop_o, frame_ovr_o
    );

    modport slave (
        input  cc_en_i, wsync_i, rsync_i, hmove_i, vsync_i, vblank_i, clr_err_i, pix_ready_i,
        output cpu_rdy_o, hcount_o, vcount_o, hblank_o, line_start_o, frame_start_o,
               pix_valid_o, pix_x_o, pix_y_o, pix_drop_o, frame_ovr_o
    );
endinterface

// File: rtl/tia_beam_scheduler.sv
// Purpose: TIA beam timing - colour-clock h/v counters, blanking, WSYNC stall, HMOVE blank, pixel requests.
// Latency: all outputs registered one clk after the causing strobe / colour-clock enable.
// Backpressure: one-deep pixel holding register; a request arriving while it is stalled is dropped (sticky flag).
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   bus     - tia_beam_scheduler_if.slave: strobes/levels in, beam status and pixel request out
module tia_beam_scheduler #(
    parameter int H_TOTAL   = 228,
    parameter int H_BLANK   = 68,
    parameter int HMOVE_EXT = 8,
    parameter int V_TOTAL   = 262,
    parameter int V_FIRST   = 40,
    parameter int V_LINES   = 192
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    tia_beam_scheduler_if.slave bus
);

    localparam logic [7:0] LP_H_LAST      = 8'(H_TOTAL - 1);
    localparam logic [7:0] LP_H_RSYNC     = 8'(H_TOTAL - 3);
    localparam logic [7:0] LP_H_BLANK     = 8'(H_BLANK);
    localparam logic [7:0] LP_H_BLANK_EXT = 8'(H_BLANK + HMOVE_EXT);
    localparam logic [8:0] LP_V_LAST      = 9'(V_TOTAL - 1);
    localparam logic [8:0] LP_V_FIRST     = 9'(V_FIRST);
    localparam logic [8:0] LP_V_END       = 9'(V_FIRST + V_LINES);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic [7:0] r_hcount;
    logic [8:0] r_vcount;
    logic       r_hmove_ext;
    logic       r_hblank;
    logic       r_line_start;
    logic       r_frame_start;
    logic       r_frame_pend;
    logic       r_vsync_d;
    state_t     r_state;
    logic       r_pix_valid;
    logic [7:0] r_pix_x;
    logic [7:0] r_pix_y;
    logic       r_pix_drop;
    logic       r_frame_ovr;

    // ---------------------------------------------------------------
    // Next-state wires
    // ---------------------------------------------------------------
    logic       w_wrap;
    logic [7:0] w_hcount_nxt;
    logic [8:0] w_vcount_nxt;
    logic       w_hmove_ext_nxt;
    logic       w_hblank_nxt;
    logic       w_vsync_fall;
    logic       w_frame_pend_nxt;
    logic       w_ovr_set;
    logic       w_pix_req;
    logic       w_pix_xfer;
    logic       w_pix_load;
    logic       w_pix_drop_set;
    logic [7:0] w_pix_x_nxt;
    logic [7:0] w_pix_y_nxt;
    state_t     w_state_nxt;
    logic       w_cpu_rdy;

    // RSYNC outranks the line wrap, so a wrap is only taken when no RSYNC is present.
    assign w_wrap = bus.cc_en_i && (r_hcount == LP_H_LAST) && !bus.rsync_i;

    always_comb begin
        w_hcount_nxt = r_hcount;
        if (bus.rsync_i) begin
            w_hcount_nxt = LP_H_RSYNC;
        end else if (w_wrap) begin
            w_hcount_nxt = '0;
        end else if (bus.cc_en_i) begin
            w_hcount_nxt = r_hcount + 8'd1;
        end
    end

    // A pending VSYNC restarts the frame at the wrap; otherwise vcount saturates.
    always_comb begin
        w_vcount_nxt = r_vcount;
        if (w_wrap) begin
            if (r_frame_pend) begin
                w_vcount_nxt = '0;
            end else if (r_vcount != LP_V_LAST) begin
                w_vcount_nxt = r_vcount + 9'd1;
            end
        end
    end

    assign w_ovr_set = w_wrap && (w_vcount_nxt == LP_V_LAST);

    // HMOVE only extends blank if it arrives while the line is still inside the normal blank.
    always_comb begin
        w_hmove_ext_nxt = r_hmove_ext;
        if (w_wrap) begin
            w_hmove_ext_nxt = 1'b0;
        end else if (bus.hmove_i && (r_hcount < LP_H_BLANK)) begin
            w_hmove_ext_nxt = 1'b1;
        end
    end

    // hblank is computed from next-state values so the register lines up with hcount_o.
    assign w_hblank_nxt = (w_hcount_nxt < LP_H_BLANK) ||
                          (w_hmove_ext_nxt && (w_hcount_nxt < LP_H_BLANK_EXT));

    assign w_vsync_fall = r_vsync_d && !bus.vsync_i;

    // A fresh VSYNC falling edge re-arms even if the old pending restart is consumed now.
    always_comb begin
        w_frame_pend_nxt = r_frame_pend;
        if (w_wrap && r_frame_pend) begin
            w_frame_pend_nxt = 1'b0;
        end
        if (w_vsync_fall) begin
            w_frame_pend_nxt = 1'b1;
        end
    end

    // Pixel request: one per visible colour clock of a forwarded line.
    assign w_pix_req      = bus.cc_en_i && !w_hblank_nxt && !bus.vblank_i &&
                            (r_vcount >= LP_V_FIRST) && (r_vcount < LP_V_END);
    assign w_pix_xfer     = r_pix_valid && bus.pix_ready_i;
    assign w_pix_load     = w_pix_req && (!r_pix_valid || bus.pix_ready_i);
    assign w_pix_drop_set = w_pix_req && r_pix_valid && !bus.pix_ready_i;
    assign w_pix_x_nxt    = w_hcount_nxt - LP_H_BLANK;
    assign w_pix_y_nxt    = 8'(r_vcount - LP_V_FIRST);

    // ---------------------------------------------------------------
    // WSYNC FSM
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_rdy   = 1'b1;
        case (r_state)
            ST_RUN: begin
                if (bus.wsync_i) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                w_cpu_rdy = 1'b0;
                // Only a real wrap releases; an RSYNC merely shortens the line.
                if (w_wrap) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Beam and pixel registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hmove_ext   <= 1'b0;
            r_hblank      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_pend  <= 1'b0;
            r_vsync_d     <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_drop    <= 1'b0;
            r_frame_ovr   <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hmove_ext   <= w_hmove_ext_nxt;
            r_hblank      <= w_hblank_nxt;
            r_line_start  <= w_wrap;
            r_frame_start <= w_wrap && r_frame_pend;
            r_frame_pend  <= w_frame_pend_nxt;
            r_vsync_d     <= bus.vsync_i;

            if (w_pix_load) begin
                r_pix_valid <= 1'b1;
                r_pix_x     <= w_pix_x_nxt;
                r_pix_y     <= w_pix_y_nxt;
            end else if (w_pix_xfer) begin
                r_pix_valid <= 1'b0;
            end

            // Sticky flags: a set in the same cycle as the clear wins.
            r_pix_drop  <= w_pix_drop_set | (r_pix_drop & ~bus.clr_err_i);
            r_frame_ovr <= w_ovr_set | (r_frame_ovr & ~bus.clr_err_i);
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.cpu_rdy_o     = w_cpu_rdy;
    assign bus.hcount_o      = r_hcount;
    assign bus.vcount_o      = r_vcount;
    assign bus.hblank_o      = r_hblank;
    assign bus.line_start_o  = r_line_start;
    assign bus.frame_start_o = r_frame_start;
    assign bus.pix_valid_o   = r_pix_valid;
    assign bus.pix_x_o       = r_pix_x;
    assign bus.pix_y_o       = r_pix_y;
    assign bus.pix_drop_o    = r_pix_drop;
    assign bus.frame_ovr_o   = r_frame_ovr;

endmodule

// File: tb/tb_tia_beam_scheduler.sv
// Purpose: directed self-checking bench for tia_beam_scheduler (vector table plus corner-case sequences).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: pixel consumer ready is driven directly per sequence.
module tb_tia_beam_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tia_beam_scheduler_if bif ();

    tia_beam_scheduler dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic cc;
        logic ws;
        logic rs;
        logic hm;
        int   h;
        int   v;
        logic rdy;
        logic ls;
        logic hb;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.cc_en_i     = 1'b0;
        bif.wsync_i     = 1'b0;
        bif.rsync_i     = 1'b0;
        bif.hmove_i     = 1'b0;
        bif.vsync_i     = 1'b0;
        bif.vblank_i    = 1'b1;
        bif.clr_err_i   = 1'b0;
        bif.pix_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Free-run until hcount_o reaches h (bounded).
    task automatic run_until_h(input int h);
        int k = 0;
        bif.cc_en_i = 1'b1;
        while (int'(bif.hcount_o) != h && k < 300) begin
            tick();
            k++;
        end
        chk("reach_hcount", 32'(bif.hcount_o), 32'(h));
    endtask

    // Fast-forward whole lines using RSYNC-shortened lines (4 clocks each); ends just after a wrap.
    task automatic goto_line(input int v);
        int k = 0;
        bif.cc_en_i  = 1'b1;
        bif.vblank_i = 1'b1;
        while (int'(bif.vcount_o) != v && k < 2000) begin
            bif.rsync_i = 1'b1;
            tick();
            bif.rsync_i = 1'b0;
            tick();
            tick();
            tick();
            k++;
        end
        chk("goto_line", 32'(bif.vcount_o), 32'(v));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //              cc    ws    rs    hm     h   v   rdy   ls    hb
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,   0,  0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1,  0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1,   2,  0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 225,  0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 225,  0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 226,  0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 227,  0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,   0,  1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,   0,  1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,   1,  1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 225,  1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 226,  1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 227,  1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0,   0,  2, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 225,  2, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 226,  2, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 227,  2, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 225,  2, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 226,  2, 1'b1, 1'b0, 1'b0};

        // ---------------- vector table: RSYNC/WSYNC/HMOVE interplay from reset
        do_reset();
        for (int i = 0; i < 19; i++) begin
            bif.cc_en_i = vecs[i].cc;
            bif.wsync_i = vecs[i].ws;
            bif.rsync_i = vecs[i].rs;
            bif.hmove_i = vecs[i].hm;
            tick();
            chk($sformatf("vec%0d_hcount", i), 32'(bif.hcount_o), 32'(vecs[i].h));
            chk($sformatf("vec%0d_vcount", i), 32'(bif.vcount_o), 32'(vecs[i].v));
            chk($sformatf("vec%0d_cpu_rdy", i), 32'(bif.cpu_rdy_o), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_line_start", i), 32'(bif.line_start_o), 32'(vecs[i].ls));
            chk($sformatf("vec%0d_hblank", i), 32'(bif.hblank_o), 32'(vecs[i].hb));
        end
        idle_inputs();

        // ---------------- reset values, then free-run two lines
        do_reset();
        chk("rst_hcount", 32'(bif.hcount_o), 0);
        chk("rst_vcount", 32'(bif.vcount_o), 0);
        chk("rst_hblank", 32'(bif.hblank_o), 1);
        chk("rst_cpu_rdy", 32'(bif.cpu_rdy_o), 1);
        chk("rst_line_start", 32'(bif.line_start_o), 0);
        chk("rst_frame_start", 32'(bif.frame_start_o), 0);
        chk("rst_pix_valid", 32'(bif.pix_valid_o), 0);
        chk("rst_pix_x", 32'(bif.pix_x_o), 0);
        chk("rst_pix_y", 32'(bif.pix_y_o), 0);
        chk("rst_pix_drop", 32'(bif.pix_drop_o), 0);
        chk("rst_frame_ovr", 32'(bif.frame_ovr_o), 0);

        bif.cc_en_i = 1'b1;
        for (int k = 1; k <= 2 * 228 + 5; k++) begin
            tick();
            chk("free_hcount", 32'(bif.hcount_o), 32'(k % 228));
            chk("free_vcount", 32'(bif.vcount_o), 32'(k / 228));
            chk("free_line_start", 32'(bif.line_start_o), 32'((k % 228) == 0));
            chk("free_hblank", 32'(bif.hblank_o), 32'((k % 228) < 68));
        end

        // ---------------- WSYNC at hcount 100, then at hcount 227 (coincident with wrap)
        run_until_h(100);
        bif.wsync_i = 1'b1;
        tick();
        bif.wsync_i = 1'b0;
        chk("wsync100_halt", 32'(bif.cpu_rdy_o), 0);
        run_until_h(227);
        chk("wsync100_still_halt", 32'(bif.cpu_rdy_o), 0);
        tick();
        chk("wsync100_release", 32'(bif.cpu_rdy_o), 1);
        run_until_h(227);
        chk("wsync227_before", 32'(bif.cpu_rdy_o), 1);
        bif.wsync_i = 1'b1;
        tick();
        bif.wsync_i = 1'b0;
        chk("wsync227_halt", 32'(bif.cpu_rdy_o), 0);
        run_until_h(227);
        chk("wsync227_full_line", 32'(bif.cpu_rdy_o), 0);
        tick();
        chk("wsync227_release", 32'(bif.cpu_rdy_o), 1);

        // ---------------- HMOVE at hcount 10 extends blank to 75; next line back to 67
        run_until_h(10);
        bif.hmove_i = 1'b1;
        tick();
        bif.hmove_i = 1'b0;
        chk("hmove_hblank_h11", 32'(bif.hblank_o), 1);
        for (int x = 12; x < 228; x++) begin
            tick();
            chk("hmove_ext_hblank", 32'(bif.hblank_o), 32'(x < 76));
        end
        chk("hmove_line_end", 32'(bif.hcount_o), 227);
        tick();
        chk("hmove_next_h0_blank", 32'(bif.hblank_o), 1);
        for (int x = 1; x < 228; x++) begin
            if (x == 121) bif.hmove_i = 1'b1;
            tick();
            bif.hmove_i = 1'b0;
            chk("hmove_late_hblank", 32'(bif.hblank_o), 32'(x < 68));
        end

        // ---------------- reset while halted releases the CPU immediately
        bif.wsync_i = 1'b1;
        tick();
        bif.wsync_i = 1'b0;
        tick();
        chk("halt_before_reset", 32'(bif.cpu_rdy_o), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_halt_rdy", 32'(bif.cpu_rdy_o), 1);
        chk("reset_mid_halt_hcount", 32'(bif.hcount_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // ---------------- VSYNC falling edge on line 5
        goto_line(5);
        bif.vsync_i = 1'b1;
        tick();
        bif.vsync_i = 1'b0;
        tick();
        chk("vsync_vcount_hold", 32'(bif.vcount_o), 5);
        run_until_h(227);
        chk("vsync_no_early_fs", 32'(bif.frame_start_o), 0);
        tick();
        chk("vsync_vcount0", 32'(bif.vcount_o), 0);
        chk("vsync_frame_start", 32'(bif.frame_start_o), 1);
        chk("vsync_line_start", 32'(bif.line_start_o), 1);
        tick();
        chk("vsync_fs_pulse_end", 32'(bif.frame_start_o), 0);
        run_until_h(227);
        tick();
        chk("vsync_next_line", 32'(bif.vcount_o), 1);
        chk("vsync_pend_cleared", 32'(bif.frame_start_o), 0);

        // ---------------- pixel requests: line 39 none, line 40 full, line 41 stalled
        goto_line(39);
        bif.vblank_i    = 1'b0;
        bif.pix_ready_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 228; k++) begin
            tick();
            if (bif.pix_valid_o) cnt++;
        end
        chk("pix_line39_none", 32'(cnt), 0);
        chk("pix_line40_reached", 32'(bif.vcount_o), 40);

        cnt = 0;
        for (int k = 0; k < 228; k++) begin
            tick();
            if (bif.pix_valid_o) begin
                chk("pix_x_seq", 32'(bif.pix_x_o), 32'(cnt));
                chk("pix_y_line40", 32'(bif.pix_y_o), 0);
                cnt++;
            end
        end
        chk("pix_count_160", 32'(cnt), 160);
        chk("pix_valid_after_line", 32'(bif.pix_valid_o), 0);
        chk("pix_drop_none", 32'(bif.pix_drop_o), 0);

        bif.pix_ready_i = 1'b0;
        run_until_h(68);
        chk("stall_first_valid", 32'(bif.pix_valid_o), 1);
        chk("stall_first_x", 32'(bif.pix_x_o), 0);
        chk("stall_first_y", 32'(bif.pix_y_o), 1);
        chk("stall_no_drop_yet", 32'(bif.pix_drop_o), 0);
        tick();
        chk("stall_drop_set", 32'(bif.pix_drop_o), 1);
        chk("stall_x_kept", 32'(bif.pix_x_o), 0);
        run_until_h(227);
        chk("stall_x_kept_eol", 32'(bif.pix_x_o), 0);
        chk("stall_valid_eol", 32'(bif.pix_valid_o), 1);
        bif.vblank_i = 1'b1;
        tick();
        bif.clr_err_i = 1'b1;
        tick();
        bif.clr_err_i = 1'b0;
        chk("clr_drop", 32'(bif.pix_drop_o), 0);
        chk("clr_valid_held", 32'(bif.pix_valid_o), 1);
        bif.vblank_i = 1'b0;
        run_until_h(100);
        bif.clr_err_i = 1'b1;
        tick();
        bif.clr_err_i = 1'b0;
        chk("drop_set_beats_clr", 32'(bif.pix_drop_o), 1);
        bif.vblank_i  = 1'b1;
        bif.clr_err_i = 1'b1;
        tick();
        bif.clr_err_i = 1'b0;
        chk("drop_clr_again", 32'(bif.pix_drop_o), 0);
        bif.pix_ready_i = 1'b1;
        tick();
        chk("pix_transfer_drops_valid", 32'(bif.pix_valid_o), 0);

        // ---------------- vcount saturation and frame overrun
        goto_line(260);
        chk("ovr_not_yet", 32'(bif.frame_ovr_o), 0);
        run_until_h(227);
        tick();
        chk("ovr_vcount261", 32'(bif.vcount_o), 261);
        chk("ovr_set", 32'(bif.frame_ovr_o), 1);
        chk("ovr_line_start", 32'(bif.line_start_o), 1);
        run_until_h(227);
        tick();
        chk("vcount_saturate", 32'(bif.vcount_o), 261);
        tick();
        bif.clr_err_i = 1'b1;
        tick();
        bif.clr_err_i = 1'b0;
        chk("ovr_cleared", 32'(bif.frame_ovr_o), 0);
        bif.vsync_i = 1'b1;
        tick();
        bif.vsync_i = 1'b0;
        run_until_h(227);
        tick();
        chk("ovr_recover_vcount", 32'(bif.vcount_o), 0);
        chk("ovr_recover_fs", 32'(bif.frame_start_o), 1);
        chk("ovr_stays_clear", 32'(bif.frame_ovr_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
